haar_pair_stream: RTL

//  Streaming 1-D Haar analysis stage. Pairs consecutive input samples (even a, odd b) and emits one

---
 rtl/haar_pkg.sv | 21 ++
 rtl/haar_skid_buf.sv | 77 +++++++
 rtl/haar_pair_stream.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/haar_pkg.sv
// Shared types and defaults for the streaming Haar analysis stage.
// Holds the pairing phase encoding and the default result record.
package haar_pkg;

    localparam int HAAR_DATA_W = 8;
    localparam int HAAR_CNT_W  = 18;

    typedef enum logic {
        PHASE_EVEN = 1'b0,
        PHASE_ODD  = 1'b1
    } phase_t;

    // Result record at the default sample width.
    // The top declares its own copy sized from its DATA_W parameter.
    typedef struct packed {
        logic [HAAR_DATA_W:0] s;
        logic [HAAR_DATA_W:0] d;
        logic                 last;
    } haar_res_t;

endpackage

// File: rtl/haar_skid_buf.sv
// Two-entry result buffer with a registered push-side ready and a registered head entry.
// The push side only sees its own flop, so out_ready never reaches in_ready combinationally.
module haar_skid_buf #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    input  logic         pop_ready
);

    logic [1:0]   count_r;
    logic [1:0]   count_nxt_s;
    logic [W-1:0] mem0_r;
    logic [W-1:0] mem1_r;
    logic         ready_r;
    logic         valid_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign do_push_s  = push_valid & ready_r;
    assign do_pop_s   = valid_r & pop_ready;
    assign push_ready = ready_r;
    assign pop_valid  = valid_r;
    assign pop_data   = mem0_r;

    // Occupancy after this cycle's push/pop.
    // A push is never accepted while full, so pop-then-push needs no extra case.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy plus the registered ready/valid flags derived from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 2'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < 2'd2);
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

    // Entry storage; the head (mem0) holds still until it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_r <= {W{1'b0}};
            mem1_r <= {W{1'b0}};
        end else if (do_pop_s) begin
            if (do_push_s && (count_r == 2'd1)) begin
                mem0_r <= push_data;
            end else begin
                mem0_r <= mem1_r;
            end
        end else if (do_push_s) begin
            if (count_r == 2'd0) begin
                mem0_r <= push_data;
            end else begin
                mem1_r <= push_data;
            end
        end else begin
            mem0_r <= mem0_r;
        end
    end

endmodule

// File: rtl/haar_pair_stream.sv
// Streaming 1-D Haar analysis: pairs even/odd samples, emits sum/difference per pair.
// Odd-length rows are closed by mirroring the last sample, giving the pair (a,a).
module haar_pair_stream
    import haar_pkg::*;
#(
    parameter int DATA_W = HAAR_DATA_W,
    parameter int CNT_W  = HAAR_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avg_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W:0]   out_s,
    output logic [DATA_W:0]   out_d,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pair_cnt
);

    localparam int RES_W = 2 * (DATA_W + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [DATA_W:0] s;
        logic [DATA_W:0] d;
        logic            last;
    } res_t;

    phase_t            phase_r;
    phase_t            phase_nxt_s;
    logic [DATA_W-1:0] hold_r;
    logic              hold_load_s;
    logic              push_s;
    logic              in_fire_s;
    logic              buf_ready_s;
    logic              pop_valid_s;
    logic              pop_fire_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    res_t              res_s;
    res_t              head_s;
    logic [CNT_W-1:0]  pair_cnt_r;

    assign in_ready   = buf_ready_s;
    assign in_fire_s  = in_valid & buf_ready_s;
    assign pop_fire_s = pop_valid_s & out_ready;

    // Pairing FSM: decides whether the accepted sample is held or completes a result.
    always_comb begin
        phase_nxt_s = phase_r;
        hold_load_s = 1'b0;
        push_s      = 1'b0;
        op_a_s      = hold_r;
        op_b_s      = in_data;
        case (phase_r)
            PHASE_EVEN: begin
                if (in_fire_s && in_last) begin
                    push_s = 1'b1;
                    op_a_s = in_data;
                end else if (in_fire_s) begin
                    hold_load_s = 1'b1;
                    phase_nxt_s = PHASE_ODD;
                end else begin
                    phase_nxt_s = PHASE_EVEN;
                end
            end
            PHASE_ODD: begin
                if (in_fire_s) begin
                    push_s      = 1'b1;
                    phase_nxt_s = PHASE_EVEN;
                end else begin
                    phase_nxt_s = PHASE_ODD;
                end
            end
            default: phase_nxt_s = PHASE_EVEN;
        endcase
    end

    // Sum/difference at DATA_W+1 bits; halving keeps the sign bit of the difference.
    always_comb begin
        sum_s  = {1'b0, op_a_s} + {1'b0, op_b_s};
        diff_s = {1'b0, op_a_s} - {1'b0, op_b_s};
        res_s.last = in_last;
        if (avg_mode) begin
            res_s.s = {1'b0, sum_s[DATA_W:1]};
            res_s.d = {diff_s[DATA_W], diff_s[DATA_W:1]};
        end else begin
            res_s.s = sum_s;
            res_s.d = diff_s;
        end
    end

    // Phase and held even-sample registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= PHASE_EVEN;
            hold_r  <= {DATA_W{1'b0}};
        end else begin
            phase_r <= phase_nxt_s;
            if (hold_load_s) begin
                hold_r <= in_data;
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Pair counter advances on output handshakes, wrapping silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_fire_s) begin
            pair_cnt_r <= pair_cnt_r + CNT_ONE;
        end else begin
            pair_cnt_r <= pair_cnt_r;
        end
    end

    haar_skid_buf #(
        .W (RES_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_s),
        .push_data  (res_s),
        .push_ready (buf_ready_s),
        .pop_valid  (pop_valid_s),
        .pop_data   (head_s),
        .pop_ready  (out_ready)
    );

    assign out_valid = pop_valid_s;
    assign out_s     = head_s.s;
    assign out_d     = head_s.d;
    assign out_last  = head_s.last;
    assign pair_cnt  = pair_cnt_r;

endmodule
